// File: rtl/byte_rom_responder_pkg.sv
// Shared definitions for the byte ROM responder and the fetch-side model.
package byte_rom_responder_pkg;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t WAIT = 1'b1;

  localparam logic [7:0] ERR_FILL    = 8'h00;
  localparam int         LATENCY_MAX = 15;

  function automatic bit latency_ok(input int lat);
    return (lat >= 0) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/byte_rom_responder_toggle_sync.sv
// Two-flop synchronizer for a two-phase request toggle; emits one pulse per level change.
module toggle_sync_detect (
  input  logic clk,
  input  logic rst,
  input  logic toggle,
  output logic req
);

  logic       s1, s2, prev;
  logic [1:0] arm;
  logic       armed;

  assign armed = arm[1];
  assign req   = armed & (s2 != prev);

  // Arming spans the sync depth: until s2 holds a real sample, prev follows s1
  // so a level held high across reset is absorbed instead of seen as a toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      arm  <= 2'b00;
    end else begin
      s1   <= toggle;
      s2   <= s1;
      prev <= armed ? s2 : s1;
      arm  <= {arm[0], 1'b1};
    end
  end

endmodule

// File: rtl/byte_rom_responder.sv
// Byte-wide ROM responder: toggle-triggered lookup with a one-deep request queue.
//   state | meaning
//   IDLE  | no request in flight; readyOut holds the last result
//   WAIT  | counting down access latency for the latched address
module byte_rom_responder
  import byte_rom_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              triggerIn,
  input  logic [31:0]       addrIn,
  output logic [7:0]        dataOut,
  output logic              readyOut,
  output logic              errOut,
  input  logic              loadEn,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [7:0]        loadData
);

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("byte_rom_responder: LATENCY out of range");
  end

  localparam logic [3:0] LAT_V = 4'(LATENCY);

  logic [7:0]        mem [2**ADDR_W];
  state_t            state;
  logic [3:0]        counter;
  logic              pending;
  logic [ADDR_W-1:0] addr_q;
  logic              range_bad;
  logic              req;
  logic [7:0]        rd_byte;

  toggle_sync_detect u_sync (
    .clk    (clk),
    .rst    (rst),
    .toggle (triggerIn),
    .req    (req)
  );

  always_ff @(posedge clk) begin
    if (loadEn) mem[loadAddr] <= loadData;
  end

  // A load landing on the address being returned this edge wins over the old byte.
  always_comb begin
    rd_byte = mem[addr_q];
    if (loadEn && (loadAddr == addr_q)) rd_byte = loadData;
    if (range_bad) rd_byte = ERR_FILL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= 4'd0;
      pending   <= 1'b0;
      addr_q    <= '0;
      range_bad <= 1'b0;
      dataOut   <= 8'h00;
      readyOut  <= 1'b0;
      errOut    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q    <= addrIn[ADDR_W-1:0];
            range_bad <= |addrIn[31:ADDR_W];
            readyOut  <= 1'b0;
            counter   <= LAT_V;
            state     <= WAIT;
          end
        end
        default: begin
          if (counter != 4'd0) begin
            counter  <= counter - 4'd1;
            readyOut <= 1'b0;
            if (req) begin
              if (pending) errOut  <= 1'b1;
              else         pending <= 1'b1;
            end
          end else begin
            dataOut  <= rd_byte;
            readyOut <= 1'b1;
            if (range_bad) errOut <= 1'b1;
            // A toggle arriving on the data-valid edge is queued rather than lost.
            if (pending || req) begin
              pending   <= pending & req;
              addr_q    <= addrIn[ADDR_W-1:0];
              range_bad <= |addrIn[31:ADDR_W];
              counter   <= LAT_V;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_rom_responder.sv
// Directed bench with a scoreboard queue of expected bytes for byte_rom_responder.
module tb_byte_rom_responder;
  import byte_rom_responder_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              triggerIn = 1'b1;
  logic [31:0]       addrIn = '0;
  logic [7:0]        dataOut;
  logic              readyOut;
  logic              errOut;
  logic              loadEn = 1'b0;
  logic [ADDR_W-1:0] loadAddr = '0;
  logic [7:0]        loadData = '0;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] sb [$];

  byte_rom_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .triggerIn(triggerIn),
    .addrIn   (addrIn),
    .dataOut  (dataOut),
    .readyOut (readyOut),
    .errOut   (errOut),
    .loadEn   (loadEn),
    .loadAddr (loadAddr),
    .loadData (loadData)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Issue one request, then wait for readyOut to rise and compare against the scoreboard.
  task automatic do_req(input logic [31:0] a, input logic [7:0] exp, input string tag);
    bit         got = 0;
    bit         seen_low;
    int         edges = 0;
    logic [7:0] e;
    @(negedge clk);
    addrIn = a;
    triggerIn = ~triggerIn;
    sb.push_back(exp);
    seen_low = !readyOut;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      if (!readyOut) seen_low = 1;
      else if (seen_low) begin got = 1; edges = k; end
    end
    check({tag, " ready"}, 32'(got), 32'd1);
    check({tag, " latency"}, edges, LAT + 4);
    e = sb.pop_front();
    check({tag, " data"}, 32'(dataOut), 32'(e));
  endtask

  initial begin
    bit         any_ready;
    int         rises;
    bit         prev_rdy;
    logic [7:0] e;

    if (!latency_ok(LAT)) $fatal(1, "bad LAT");

    // Reset with triggerIn high, then idle: no request may be seen.
    repeat (3) @(negedge clk);
    check("rst ready", 32'(readyOut), 32'd0);
    check("rst data", 32'(dataOut), 32'h00);
    check("rst err", 32'(errOut), 32'd0);
    rst = 1'b0;
    any_ready = 0;
    repeat (10) begin
      @(negedge clk);
      if (readyOut) any_ready = 1;
    end
    check("idle no ready", 32'(any_ready), 32'd0);
    check("idle err", 32'(errOut), 32'd0);

    load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
    load(5, 8'h5A);

    do_req(32'd0, 8'h11, "rd0");
    do_req(32'd1, 8'h22, "rd1");
    do_req(32'd2, 8'h33, "rd2");
    do_req(32'd3, 8'h44, "rd3");
    check("legal err", 32'(errOut), 32'd0);

    do_req(32'h0000_0400, ERR_FILL, "range");
    check("range err", 32'(errOut), 32'd1);
    do_req(32'd1, 8'h22, "after range");
    check("err sticky", 32'(errOut), 32'd1);

    // Two toggles one cycle apart: second is queued and serviced back to back.
    do_reset();
    @(negedge clk);
    addrIn = 32'd2;
    triggerIn = ~triggerIn; sb.push_back(8'h33);
    @(negedge clk);
    triggerIn = ~triggerIn; sb.push_back(8'h33);
    rises = 0;
    prev_rdy = readyOut;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (readyOut && !prev_rdy) begin
        rises++;
        e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        check("b2b data", 32'(dataOut), 32'(e));
      end
      prev_rdy = readyOut;
    end
    check("b2b rises", rises, 2);
    check("b2b err", 32'(errOut), 32'd0);

    // Three toggles inside one access window overrun the queue.
    @(negedge clk); triggerIn = ~triggerIn;
    @(negedge clk); triggerIn = ~triggerIn;
    @(negedge clk); triggerIn = ~triggerIn;
    repeat (20) @(negedge clk);
    check("overrun err", 32'(errOut), 32'd1);

    // Load on the data-valid edge to the address being returned.
    do_reset();
    @(negedge clk);
    addrIn = 32'd5;
    triggerIn = ~triggerIn;
    repeat (5) @(posedge clk);
    @(negedge clk);
    loadEn = 1'b1; loadAddr = 10'd5; loadData = 8'hA5;
    @(posedge clk); #1;
    check("raw ready", 32'(readyOut), 32'd1);
    check("raw data", 32'(dataOut), 32'hA5);
    @(negedge clk);
    loadEn = 1'b0;
    do_req(32'd5, 8'hA5, "raw reread");

    // Reset asserted mid-access clears outputs at once.
    @(negedge clk);
    addrIn = 32'd2;
    triggerIn = ~triggerIn;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst ready", 32'(readyOut), 32'd0);
    check("mid rst data", 32'(dataOut), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_req(32'd3, 8'h44, "post rst");
    check("post rst err", 32'(errOut), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
